fpu_div_arbiter: RTL and testbench

- Shares one FP32 Divider instance among NUM_REQ requesters (e.g. per-lane FPU front ends).
- Accepts operand pairs through valid/ready handshakes and picks the next requester round-robin.
- Drives the Divider's A/B/En, waits for its Ready pulse, and returns Result/NaN to the granted requester with a one-hot response strobe.
- Sits between the issue logic and the Divider in the FPU top.

---
 rtl/fpu_div_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fpu_div_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter
//   Shares one FP32 divider among NUM_REQ requesters. Operand pairs are accepted
//   over a valid/ready handshake, the next requester is chosen round-robin, the
//   divider is started with a single En pulse, and its Result/NaN are returned to
//   the granted requester with a one-hot, one-cycle response strobe.
//
//   Optional macro DIV_TIMEOUT_EN: adds a WAIT-state watchdog of TIMEOUT_CYCLES.
//   On expiry a quiet NaN is returned, the divider is flushed and a sticky
//   timeout_err flag is raised. Without the macro, div_flush and timeout_err are 0.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   req_valid/ready  per-requester handshake (ready is one-hot, combinational)
//   req_a, req_b     packed operands, requester i at [32i+31:32i]
//   rsp_valid        one-hot one-cycle response strobe
//   rsp_result/nan   quotient and NaN flag, held until the next capture
//   div_A/B/en       divider operands and start pulse
//   div_result/ready/nan  divider outputs (ready is a one-cycle pulse)
//   div_flush        one-cycle divider flush pulse
//   busy             high whenever the FSM is not idle
//   timeout_err      sticky watchdog flag

module fpu_div_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_result,
   output logic                   rsp_nan,
   output logic [31:0]            div_A,
   output logic [31:0]            div_B,
   output logic                   div_en,
   input  logic [31:0]            div_result,
   input  logic                   div_ready,
   input  logic                   div_nan,
   output logic                   div_flush,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("fpu_div_arbiter: unsupported parameter values");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

   state_e             state_q;
   logic [IdW-1:0]     rr_q;
   logic [IdW-1:0]     gnt_q;
   logic [31:0]        div_a_q;
   logic [31:0]        div_b_q;
   logic               div_en_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [31:0]        rsp_result_q;
   logic               rsp_nan_q;

   logic               win_found;
   logic [IdW-1:0]     win_id;
   logic [IdW-1:0]     idx_c;
   logic [31:0]        win_a;
   logic [31:0]        win_b;

`ifdef DIV_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0]    tmo_cnt_q;
   logic               div_flush_q;
   logic               timeout_err_q;
`endif

   // Round-robin search starting just after the last served requester.
   always_comb begin : arbitrate
      win_found = 1'b0;
      win_id    = '0;
      idx_c     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx_c = IdW'((32'(rr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[idx_c]) begin
            win_found = 1'b1;
            win_id    = idx_c;
         end
      end
   end

   always_comb begin : operand_mux
      win_a = '0;
      win_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_id == IdW'(i)) begin
            win_a = req_a[32*i +: 32];
            win_b = req_b[32*i +: 32];
         end
      end
   end

   // Gated by reset so a grant is never handed out in a cycle that is being discarded.
   always_comb begin : ready_gen
      req_ready = '0;
      if (state_q == StIdle && win_found && !reset) begin
         req_ready[win_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin : fsm
      if (reset) begin
         state_q      <= StIdle;
         rr_q         <= IdW'(NUM_REQ - 1);
         gnt_q        <= '0;
         div_a_q      <= '0;
         div_b_q      <= '0;
         div_en_q     <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_nan_q    <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         div_flush_q   <= 1'b0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         div_en_q    <= 1'b0;
         rsp_valid_q <= '0;
`ifdef DIV_TIMEOUT_EN
         div_flush_q <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  div_a_q  <= win_a;
                  div_b_q  <= win_b;
                  gnt_q    <= win_id;
                  div_en_q <= 1'b1;
                  state_q  <= StIssue;
               end
            end
            StIssue: begin
`ifdef DIV_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
               state_q <= StWait;
            end
            // div_A/div_B are not touched here: the divider re-reads them after En.
            StWait: begin
               if (div_ready) begin
                  rsp_result_q       <= div_result;
                  rsp_nan_q          <= div_nan;
                  rsp_valid_q[gnt_q] <= 1'b1;
                  state_q            <= StRespond;
               end
`ifdef DIV_TIMEOUT_EN
               else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_result_q       <= 32'h7FC0_0000;
                  rsp_nan_q          <= 1'b1;
                  rsp_valid_q[gnt_q] <= 1'b1;
                  timeout_err_q      <= 1'b1;
                  div_flush_q        <= 1'b1;
                  state_q            <= StRespond;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            StRespond: begin
               rr_q    <= gnt_q;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign div_A      = div_a_q;
   assign div_B      = div_b_q;
   assign div_en     = div_en_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_nan    = rsp_nan_q;
   assign busy       = (state_q != StIdle);

`ifdef DIV_TIMEOUT_EN
   assign div_flush   = div_flush_q;
   assign timeout_err = timeout_err_q;
`else
   assign div_flush   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Bench for fpu_div_arbiter: divider stub with programmable latency/result, a
// transaction-level round-robin model, and a scoreboard queue of expected responses.

module tb_fpu_div_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;
`ifdef DIV_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_result;
   logic            rsp_nan;
   logic [31:0]     div_A;
   logic [31:0]     div_B;
   logic            div_en;
   logic [31:0]     div_result = '0;
   logic            div_ready  = 1'b0;
   logic            div_nan    = 1'b0;
   logic            div_flush;
   logic            busy;
   logic            timeout_err;

   always #5 clk = ~clk;

   fpu_div_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_nan(rsp_nan),
      .div_A(div_A), .div_B(div_B), .div_en(div_en),
      .div_result(div_result), .div_ready(div_ready), .div_nan(div_nan),
      .div_flush(div_flush), .busy(busy), .timeout_err(timeout_err)
   );

   // Stub configuration: smode 0 = a+b / parity, 1 = fixed value, 2 = never ready.
   int          smode    = 0;
   int          lat_cfg  = 10;
   bit          rand_lat = 1'b0;
   int          lat      = 10;
   logic [31:0] fix_res  = '0;
   logic        fix_nan  = 1'b0;
   logic        spur     = 1'b0;
   int          scnt     = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Result is formed from div_A/div_B at the ready edge, so operands must be held.
   always @(posedge clk) begin
      div_ready <= 1'b0;
      if (reset || div_flush) scnt <= 0;
      else if (div_en) scnt <= (smode == 2) ? 0 : lat;
      else if (scnt > 0) begin
         scnt <= scnt - 1;
         if (scnt == 1) begin
            div_ready <= 1'b1;
            if (smode == 1) begin
               div_result <= fix_res;
               div_nan    <= fix_nan;
            end else begin
               div_result <= div_A + div_B;
               div_nan    <= ^(div_A ^ div_B);
            end
         end
      end
      if (spur) begin
         div_ready  <= 1'b1;
         div_result <= 32'hDEAD_BEEF;
         div_nan    <= 1'b1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int          id;
      logic [31:0] res;
      logic        nan;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          order[$];
   int          rr_m   = N - 1;
   int          done_m = 0;
   int          gnt_m  = -1;
   bit          never_m;
   bit          err_m;
   logic [31:0] a_m, b_m;
   logic [N-1:0] acc = '0;
   logic [N-1:0] exp_ready;
   int          win;
   exp_t        e, f;
   logic        exp_en, exp_busy, exp_flush;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         order.delete();
         rr_m   = N - 1;
         done_m = cyc;
         gnt_m  = -1;
         err_m  = 1'b0;
         acc    = '0;
      end else begin
         exp_ready = '0;
         win       = -1;
         if (cyc > done_m) begin
            for (int k = 1; k <= N; k++) begin
               if (win < 0 && req_valid[(rr_m + k) % N]) win = (rr_m + k) % N;
            end
         end
         if (win >= 0) begin
            exp_ready[win] = 1'b1;
            lat     = rand_lat ? int'($urandom_range(1, 12)) : lat_cfg;
            gnt_m   = cyc;
            a_m     = req_a[win*32 +: 32];
            b_m     = req_b[win*32 +: 32];
            never_m = (smode == 2);
            if (never_m) done_m = TO_EN ? cyc + 2 + TMO : 32'h3FFF_FFFF;
            else         done_m = cyc + lat + 3;
            e.id  = win;
            e.due = done_m;
            if (smode == 0) begin
               e.res = a_m + b_m;
               e.nan = ^(a_m ^ b_m);
            end else if (smode == 1) begin
               e.res = fix_res;
               e.nan = fix_nan;
            end else begin
               e.res = 32'h7FC0_0000;
               e.nan = 1'b1;
            end
            if (!never_m || TO_EN) q.push_back(e);
            rr_m = win;
            order.push_back(win);
         end
         chk("req_ready", req_ready, exp_ready);
         exp_en   = (gnt_m >= 0) && (cyc == gnt_m + 1);
         exp_busy = (gnt_m >= 0) && (cyc > gnt_m) && (cyc <= done_m);
         chk("div_en", div_en, exp_en);
         chk("busy", busy, exp_busy);
         if (exp_busy) begin
            chk("div_A_hold", div_A, a_m);
            chk("div_B_hold", div_B, b_m);
         end
         exp_flush = TO_EN && never_m && exp_busy && (cyc == done_m);
         if (exp_flush) err_m = 1'b1;
         chk("div_flush", div_flush, exp_flush);
         chk("timeout_err", timeout_err, err_m);
         if (rsp_valid != '0) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, '0);
            end else begin
               f = q.pop_front();
               chk("rsp_onehot", rsp_valid, 32'(1) << f.id);
               chk("rsp_result", rsp_result, f.res);
               chk("rsp_nan", rsp_nan, f.nan);
               chk("rsp_cycle", cyc, f.due);
            end
         end else if (q.size() != 0 && q[0].due < cyc) begin
            f = q.pop_front();
            chk("rsp_missing", rsp_valid, 32'(1) << f.id);
         end
         acc = req_ready;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_valid[i]      = 1'b1;
   endtask

   task automatic check_zero();
      chk("z_req_ready", req_ready, '0);
      chk("z_rsp_valid", rsp_valid, '0);
      chk("z_rsp_result", rsp_result, '0);
      chk("z_rsp_nan", rsp_nan, '0);
      chk("z_div_A", div_A, '0);
      chk("z_div_B", div_B, '0);
      chk("z_div_en", div_en, '0);
      chk("z_busy", busy, '0);
      chk("z_div_flush", div_flush, '0);
      chk("z_timeout_err", timeout_err, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      @(negedge clk);
      check_zero();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (!(req_valid == '0 && q.size() == 0 && cyc > done_m + 1) && n < max) begin
         step();
         n++;
      end
      if (n >= max) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_idle: still busy after %0d cycles", max);
      end
   endtask

   initial begin
      int base;
      int n;
      int exp_order[6] = '{0, 1, 2, 3, 1, 3};
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      do_reset();

      // 6.0 / 2.0 with latency 10: response 13 cycles after accept.
      smode = 1; fix_res = 32'h4040_0000; fix_nan = 1'b0; lat_cfg = 10;
      raise(0, 32'h40C0_0000, 32'h4000_0000);
      wait_idle(100);

      // Round-robin order after reset, then wrap from rr=3.
      do_reset();
      smode = 0; lat_cfg = 3;
      for (int i = 0; i < N; i++) raise(i, $urandom, $urandom);
      wait_idle(200);
      raise(3, $urandom, $urandom);
      raise(1, $urandom, $urandom);
      wait_idle(200);
      chk("order_len", order.size(), 6);
      for (int i = 0; i < 6 && i < order.size(); i++) chk("grant_order", order[i], exp_order[i]);

      // NaN result on requester 2.
      smode = 1; fix_res = 32'h7FC0_0000; fix_nan = 1'b1; lat_cfg = 5;
      raise(2, 32'h0000_0000, 32'h0000_0000);
      wait_idle(100);

      // Reset four cycles into WAIT, then a normal op on requester 2.
      smode = 1; fix_res = 32'h4040_0000; fix_nan = 1'b0; lat_cfg = 10;
      base = order.size();
      raise(0, 32'h40C0_0000, 32'h4000_0000);
      n = 0;
      while (order.size() == base && n < 20) begin
         step();
         n++;
      end
      chk("midwait_grant", order.size(), base + 1);
      while (cyc < gnt_m + 6) step();
      reset = 1'b1;
      step();
      @(negedge clk);
      check_zero();
      step();
      reset   = 1'b0;
      fix_res = 32'h3F80_0000;
      raise(2, 32'h3F80_0000, 32'h3F80_0000);
      wait_idle(100);

      // Spurious div_ready while idle.
      step();
      spur = 1'b1;
      step();
      spur = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("spur_busy", busy, 1'b0);
      chk("spur_rsp_hold", rsp_result, 32'h3F80_0000);

      // Randomised traffic with random latencies and early valid drops.
      smode = 0; rand_lat = 1'b1;
      repeat (600) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) raise(i, $urandom, $urandom);
            else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
         end
      end
      wait_idle(1000);
      rand_lat = 1'b0;

      // Divider that never answers.
      smode = 2; lat_cfg = 1;
      raise(1, 32'h4000_0000, 32'h0000_0000);
`ifdef DIV_TIMEOUT_EN
      wait_idle(200);
      repeat (3) step();
      @(negedge clk);
      chk("timeout_sticky", timeout_err, 1'b1);
`else
      repeat (1000) step();
      @(negedge clk);
      chk("hang_busy", busy, 1'b1);
      chk("hang_no_err", timeout_err, 1'b0);
      chk("hang_queue", q.size(), 0);
`endif
      do_reset();
      smode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
